// File: rtl/uart_xor_stream_top.sv
// uart_xor_stream_top: UART byte scrambler with a command parser.
// Each received data byte is XORed with a rolling KEY_BYTES-wide key and
// queued in a TX FIFO. Command bytes load a new key (CMD_SET_KEY + KEY_BYTES
// bytes), escape the next byte as data (CMD_ESC), or rewind the key index
// (CMD_IDX_RST).
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_uart_rxd       UART receive line
//   o_uart_txd       UART transmit line (idle high)
//   i_uart_cts_n     clear-to-send, active-low; high holds off new TX bytes
//   o_key_loading    high while the parser collects key bytes
//   o_overflow       sticky: a data byte was dropped on a full FIFO
//   o_fifo_count     current FIFO occupancy
//   o_dbg_state      parser state (S_OP / S_ESC / S_KEY)
// Also contains the uart_rx and uart_tx cores it instantiates.

module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic       o_rx_done,
  output logic [7:0] o_rx_data
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;

  logic          meta_q, sync_q, done_q;
  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      done_q  <= 1'b0;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      meta_q <= i_rxd;
      sync_q <= meta_q;
      done_q <= 1'b0;
      case (state_q)
        R_IDLE: if (!sync_q) begin
          state_q <= R_START;
          cnt_q   <= '0;
        end
        // Re-check the start bit at its centre to reject glitches.
        R_START: if (cnt_q == CNT_HALF) begin
          state_q <= sync_q ? R_IDLE : R_DATA;
          cnt_q   <= '0;
          bit_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        R_DATA: if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          shift_q <= {sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_q <= R_STOP;
          else bit_q <= bit_q + 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        default: if (cnt_q == CNT_LAST) begin
          state_q <= R_IDLE;
          done_q  <= sync_q;  // framing error: byte silently dropped
        end else cnt_q <= cnt_q + 1'b1;
      endcase
    end
  end

  assign o_rx_done = done_q;
  assign o_rx_data = shift_q;
endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_txd,
  output logic       o_tx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          busy_q, txd_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [8:0]    shift_q;  // data bits then the stop bit, LSB first

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
    end else if (!busy_q) begin
      if (i_tx_start) begin
        busy_q  <= 1'b1;
        txd_q   <= 1'b0;
        cnt_q   <= '0;
        bit_q   <= '0;
        shift_q <= {1'b1, i_tx_data};
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        txd_q  <= 1'b1;
      end else begin
        txd_q   <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
        bit_q   <= bit_q + 1'b1;
      end
    end else cnt_q <= cnt_q + 1'b1;
  end

  assign o_txd     = txd_q;
  assign o_tx_busy = busy_q;
endmodule

module uart_xor_stream_top #(
  parameter int                     CLOCK_FREQ  = 50_000_000,
  parameter int                     BAUD_RATE   = 9600,
  parameter int                     KEY_BYTES   = 4,
  parameter int                     FIFO_DEPTH  = 16,
  parameter logic [7:0]             CMD_SET_KEY = 8'hFF,
  parameter logic [7:0]             CMD_ESC     = 8'hFE,
  parameter logic [7:0]             CMD_IDX_RST = 8'hFD,
  parameter logic [8*KEY_BYTES-1:0] KEY_INIT    = {KEY_BYTES{8'hA5}}
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_uart_rxd,
  output logic                          o_uart_txd,
  input  logic                          i_uart_cts_n,
  output logic                          o_key_loading,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [1:0]                    o_dbg_state
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [KW-1:0] IDX_LAST  = KW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [1:0] S_OP = 2'd0, S_ESC = 2'd1, S_KEY = 2'd2;

  logic                   rx_done, tx_busy, tx_start, do_push, do_pop;
  logic [7:0]             rx_data, tx_data, key_byte;
  logic [1:0]             state_q, state_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d, shadow_q, shadow_d;
  logic [KW-1:0]          idx_q, idx_d, idx_adv, kcnt_q, kcnt_d;
  logic                   push_req_q, push_req_d;
  logic [7:0]             push_byte_q, push_byte_d;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, tx_start_q;
  logic [7:0]             mem_q [FIFO_DEPTH];

  uart_rx #(.CLKS_PER_BIT(CLOCK_FREQ / BAUD_RATE)) u_rx (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rxd(i_uart_rxd),
    .o_rx_done(rx_done), .o_rx_data(rx_data)
  );

  uart_tx #(.CLKS_PER_BIT(CLOCK_FREQ / BAUD_RATE)) u_tx (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tx_start(tx_start), .i_tx_data(tx_data),
    .o_txd(o_uart_txd), .o_tx_busy(tx_busy)
  );

  assign key_byte = key_q[{idx_q, 3'b000} +: 8];
  assign idx_adv  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  // Byte parser: acts only on rx_done. Data bytes are registered into
  // push_req_q/push_byte_q and written to the FIFO on the following cycle.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    kcnt_d      = kcnt_q;
    push_req_d  = 1'b0;
    push_byte_d = push_byte_q;
    if (rx_done) begin
      case (state_q)
        S_OP: begin
          if (rx_data == CMD_SET_KEY) begin
            state_d = S_KEY;
            kcnt_d  = '0;
          end else if (rx_data == CMD_ESC) begin
            state_d = S_ESC;
          end else if (rx_data == CMD_IDX_RST) begin
            idx_d = '0;
          end else begin
            push_req_d  = 1'b1;
            push_byte_d = rx_data ^ key_byte;
            idx_d       = idx_adv;
          end
        end
        S_ESC: begin
          push_req_d  = 1'b1;
          push_byte_d = rx_data ^ key_byte;
          idx_d       = idx_adv;
          state_d     = S_OP;
        end
        S_KEY: begin
          // Collect into the shadow; the active key swaps in one cycle on
          // the last byte so a partial load never affects the keystream.
          shadow_d[{kcnt_q, 3'b000} +: 8] = rx_data;
          if (kcnt_q == IDX_LAST) begin
            key_d   = shadow_d;
            idx_d   = '0;
            kcnt_d  = '0;
            state_d = S_OP;
          end else begin
            kcnt_d = kcnt_q + 1'b1;
          end
        end
        default: state_d = S_OP;
      endcase
    end
  end

  // TX handshake: tx_start is a one-cycle request accepted by uart_tx only
  // while tx_busy is low; tx_busy rises the cycle after tx_start, so a start
  // is never issued two cycles in a row. The FIFO head pops with the start.
  assign tx_start = (count_q != '0) && !tx_busy && !i_uart_cts_n && !tx_start_q;
  assign do_pop   = tx_start;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
  assign do_push  = push_req_q && ((count_q != FIFO_FULL) || do_pop);
  assign tx_data  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_OP;
      key_q       <= KEY_INIT;
      shadow_q    <= '0;
      idx_q       <= '0;
      kcnt_q      <= '0;
      push_req_q  <= 1'b0;
      push_byte_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      kcnt_q      <= kcnt_d;
      push_req_q  <= push_req_d;
      push_byte_q <= push_byte_d;
      count_q     <= count_d;
      tx_start_q  <= tx_start;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req_q && !do_push) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_byte_q;
  end

  assign o_key_loading = (state_q == S_KEY);
  assign o_overflow    = overflow_q;
  assign o_fifo_count  = count_q;
  assign o_dbg_state   = state_q;
endmodule

// File: tb/tb_uart_xor_stream_top.sv
// Bench for uart_xor_stream_top: bit-bangs bytes into the RX line, decodes
// the TX line into a queue, and compares against hand-computed bytes.
module tb_uart_xor_stream_top;
  localparam int BIT_CLKS = 8;  // CLOCK_FREQ / BAUD_RATE below

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       txd;
  logic       cts_n;
  logic       key_loading;
  logic       overflow;
  logic [4:0] fifo_count;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_xor_stream_top #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (125_000),
    .KEY_BYTES (4),
    .FIFO_DEPTH(16)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_uart_rxd   (rxd),
    .o_uart_txd   (txd),
    .i_uart_cts_n (cts_n),
    .o_key_loading(key_loading),
    .o_overflow   (overflow),
    .o_fifo_count (fifo_count),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: one 8N1 frame plus one idle bit time
  task automatic uart_send(input logic [7:0] b);
    @(negedge clk);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(BIT_CLKS);
    end
    rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
  endtask

  // TX line monitor: samples each bit near its centre
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        wait_clks(BIT_CLKS / 2);
        for (int i = 0; i < 8; i++) begin
          wait_clks(BIT_CLKS);
          b[i] = txd;
        end
        wait_clks(BIT_CLKS);
        check_eq("tx_stop_bit", {31'd0, txd}, 32'd1);
        got_q.push_back(b);
      end
    end
  end

  // scoreboard: wait (bounded) for n bytes, confirm no extras, compare in order
  task automatic expect_tx(input string tag, input int n);
    int waited = 0;
    while (got_q.size() < n && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    wait_clks(25 * BIT_CLKS);
    check_eq({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0)
        check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, got_q.pop_front()},
                 {24'd0, exp_q.pop_front()});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    cts_n = 1'b0;
    wait_clks(5);
    check_eq("rst_txd", {31'd0, txd}, 32'd1);
    check_eq("rst_count", {27'd0, fifo_count}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    check_eq("rst_key_loading", {31'd0, key_loading}, 32'd0);
    rst_n = 1'b1;
    wait_clks(20);

    // default key A5 A5 A5 A5
    uart_send(8'h00); uart_send(8'h3C);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h99);
    expect_tx("t1", 2);
    check_eq("t1_count", {27'd0, fifo_count}, 32'd0);
    check_eq("t1_overflow", {31'd0, overflow}, 32'd0);

    // load key 01 02 03 04
    uart_send(8'hFF);
    check_eq("t2_loading_after_ff", {31'd0, key_loading}, 32'd1);
    uart_send(8'h01); uart_send(8'h02); uart_send(8'h03);
    check_eq("t2_loading_mid", {31'd0, key_loading}, 32'd1);
    uart_send(8'h04);
    check_eq("t2_loading_done", {31'd0, key_loading}, 32'd0);
    for (int i = 0; i < 5; i++) uart_send(8'h10);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h11};
    expect_tx("t2", 5);

    // index reset between two data bytes
    uart_send(8'hFD);
    uart_send(8'h20); uart_send(8'hFD); uart_send(8'h20);
    exp_q = '{8'h21, 8'h21};
    expect_tx("t3", 2);

    // escaped command values as data
    uart_send(8'hFD);
    uart_send(8'hFE); uart_send(8'hFF);
    uart_send(8'hFE); uart_send(8'hFE);
    uart_send(8'hFE); uart_send(8'hFD);
    exp_q = '{8'hFE, 8'hFC, 8'hFE};
    expect_tx("t4", 3);

    // CTS held off: fill, overflow, then drain
    cts_n = 1'b1;
    uart_send(8'hFD);
    for (int i = 0; i < 16; i++) uart_send(8'h00);
    check_eq("t5_count_16", {27'd0, fifo_count}, 32'd16);
    check_eq("t5_no_overflow_yet", {31'd0, overflow}, 32'd0);
    uart_send(8'h00);
    check_eq("t5_overflow_17", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 3; i++) uart_send(8'h00);
    check_eq("t5_count_full", {27'd0, fifo_count}, 32'd16);
    check_eq("t5_txd_idle_held", {31'd0, txd}, 32'd1);
    cts_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    end
    expect_tx("t5", 16);
    check_eq("t5_drained", {27'd0, fifo_count}, 32'd0);
    check_eq("t5_overflow_sticky", {31'd0, overflow}, 32'd1);

    // reset mid key load with bytes queued
    cts_n = 1'b1;
    uart_send(8'h00); uart_send(8'h00); uart_send(8'h00);
    uart_send(8'hFF); uart_send(8'h11); uart_send(8'h22);
    check_eq("t6_count_before", {27'd0, fifo_count}, 32'd3);
    check_eq("t6_loading_before", {31'd0, key_loading}, 32'd1);
    rst_n = 1'b0;
    wait_clks(3);
    check_eq("t6_rst_txd", {31'd0, txd}, 32'd1);
    check_eq("t6_rst_count", {27'd0, fifo_count}, 32'd0);
    check_eq("t6_rst_loading", {31'd0, key_loading}, 32'd0);
    check_eq("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    cts_n = 1'b0;
    wait_clks(10);
    uart_send(8'h00); uart_send(8'h01);
    exp_q = '{8'hA5, 8'hA4};
    expect_tx("t6", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
